// File: rtl/spd_ctrl_pkg.sv
// Shared types, range limits and the saturation helper for the speed controller.
package spd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMP    = 2'd1,
    CRUISE  = 2'd2,
    RAMP_DN = 2'd3
  } state_t;

  localparam int SPD_MAX  = 2047;
  localparam int SPD_MIN  = -2048;
  localparam int ERR_MAX  = 511;
  localparam int ERR_MIN  = -512;
  localparam int DIFF_MAX = 127;
  localparam int DIFF_MIN = -128;

  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                    input int lo, input int hi);
    logic signed [31:0] r;
    if (v > hi) r = hi;
    else if (v < lo) r = lo;
    else r = v;
    return r;
  endfunction

endpackage

// File: rtl/spd_ctrl_pd_term.sv
// Stage-1 of the steering pipeline: error clamp, derivative history and P/D products.
module pd_term
  import spd_ctrl_pkg::*;
#(
  parameter logic signed [3:0] P_COEF = 4'sd3,
  parameter logic signed [3:0] D_COEF = 4'sd5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               err_vld,
  input  logic               clr_prev,
  input  logic signed [11:0] err,
  output logic signed [13:0] p_term,
  output logic signed [11:0] d_term
);

  logic signed [9:0]  prev_err_r;
  logic signed [9:0]  err_sat_s;
  logic signed [7:0]  diff_s;
  logic signed [31:0] esat_w_s;
  logic signed [31:0] diff_w_s;

  // Clamp the raw error and the sample-to-sample difference.
  always_comb begin
    esat_w_s  = sat_signed(32'(err), ERR_MIN, ERR_MAX);
    err_sat_s = esat_w_s[9:0];
    diff_w_s  = sat_signed(32'(err_sat_s) - 32'(prev_err_r), DIFF_MIN, DIFF_MAX);
    diff_s    = diff_w_s[7:0];
  end

  // Register the products; history is dropped whenever the controller idles.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_err_r <= 10'sd0;
      p_term     <= 14'sd0;
      d_term     <= 12'sd0;
    end else if (err_vld) begin
      prev_err_r <= clr_prev ? 10'sd0 : err_sat_s;
      p_term     <= 14'(err_sat_s) * 14'(P_COEF);
      d_term     <= 12'(diff_s) * 12'(D_COEF);
    end
  end

endmodule

// File: rtl/spd_ctrl.sv
// Forward-speed ramp FSM plus PD steering mix into saturated wheel speed commands.
// Optional integral term enabled by defining SPD_CTRL_INTEG_EN.
module spd_ctrl
  import spd_ctrl_pkg::*;
#(
  parameter logic signed [3:0] P_COEF   = 4'sd3,
  parameter logic signed [3:0] D_COEF   = 4'sd5,
  parameter logic [7:0]        RAMP_INC = 8'd16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               moving,
  input  logic [10:0]        frwrd_tgt,
  input  logic signed [11:0] err,
  input  logic               err_vld,
  output logic signed [11:0] lft_spd,
  output logic signed [11:0] rght_spd,
  output logic               out_vld,
  output logic               at_spd
);

  state_t             state_r, state_nxt_s;
  logic [10:0]        frwrd_r, frwrd_nxt_s, toward_s, down_s, frwrd_p_r;
  logic [10:0]        inc_s, dn_inc_s;
  logic               use_down_s, use_toward_s, vld_p_r, zero_p_r;
  logic signed [13:0] p_term_s;
  logic signed [11:0] d_term_s;
  logic signed [16:0] i_term_s, sum_s, shr_s;
  logic signed [11:0] pid_s, lft_s, rght_s;
  logic signed [13:0] fw_s, lsum_s, rsum_s;
  logic signed [31:0] pid_w_s, lft_w_s, rght_w_s;

  assign inc_s    = 11'(RAMP_INC);
  assign dn_inc_s = 11'({RAMP_INC, 1'b0});

  // Candidate speeds: one step toward target, or a double step toward zero.
  always_comb begin
    if (frwrd_r < frwrd_tgt) begin
      if ((frwrd_tgt - frwrd_r) > inc_s) toward_s = frwrd_r + inc_s;
      else toward_s = frwrd_tgt;
    end else if (frwrd_r > frwrd_tgt) begin
      if ((frwrd_r - frwrd_tgt) > inc_s) toward_s = frwrd_r - inc_s;
      else toward_s = frwrd_tgt;
    end else begin
      toward_s = frwrd_tgt;
    end
    if (frwrd_r > dn_inc_s) down_s = frwrd_r - dn_inc_s;
    else down_s = 11'd0;
  end

  // Next state and speed; the entered state's action applies on the same sample.
  always_comb begin
    use_down_s   = 1'b0;
    use_toward_s = 1'b0;
    case (state_r)
      IDLE:    use_toward_s = moving && (frwrd_tgt != 11'd0);
      default: begin
        use_down_s   = !moving;
        use_toward_s = moving;
      end
    endcase
    if (use_down_s) begin
      frwrd_nxt_s = down_s;
      state_nxt_s = (down_s == 11'd0) ? IDLE : RAMP_DN;
    end else if (use_toward_s) begin
      frwrd_nxt_s = toward_s;
      if (toward_s != frwrd_tgt) state_nxt_s = RAMP;
      else if (frwrd_tgt == 11'd0) state_nxt_s = IDLE;
      else state_nxt_s = CRUISE;
    end else begin
      frwrd_nxt_s = 11'd0;
      state_nxt_s = IDLE;
    end
  end

  // FSM state plus the stage-1 copy of speed so back-to-back samples stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      frwrd_r   <= 11'd0;
      at_spd    <= 1'b0;
      vld_p_r   <= 1'b0;
      frwrd_p_r <= 11'd0;
      zero_p_r  <= 1'b0;
    end else begin
      vld_p_r <= err_vld;
      if (err_vld) begin
        state_r   <= state_nxt_s;
        frwrd_r   <= frwrd_nxt_s;
        at_spd    <= (state_nxt_s == CRUISE);
        frwrd_p_r <= frwrd_nxt_s;
        zero_p_r  <= (state_nxt_s == IDLE);
      end
    end
  end

  pd_term #(.P_COEF(P_COEF), .D_COEF(D_COEF)) u_pd_term (
    .clk      (clk),
    .rst      (rst),
    .err_vld  (err_vld),
    .clr_prev (state_nxt_s == IDLE),
    .err      (err),
    .p_term   (p_term_s),
    .d_term   (d_term_s)
  );

`ifdef SPD_CTRL_INTEG_EN
  logic signed [15:0] integ_r, integ_nxt_s, integ_sh_s;
  logic signed [9:0]  i_esat_s;
  logic signed [31:0] i_esat_w_s, integ_w_s;
  logic signed [16:0] i_term_r;

  // Accumulate only while cruising; any other state restarts from zero.
  always_comb begin
    i_esat_w_s = sat_signed(32'(err), ERR_MIN, ERR_MAX);
    i_esat_s   = i_esat_w_s[9:0];
    if ((state_r == CRUISE) && (state_nxt_s == CRUISE)) begin
      integ_w_s = sat_signed(32'(integ_r) + 32'(i_esat_s), -32'sd32768, 32'sd32767);
    end else begin
      integ_w_s = 32'sd0;
    end
    integ_nxt_s = integ_w_s[15:0];
    integ_sh_s  = integ_nxt_s >>> 6;
  end

  // Integrator and its stage-1 term.
  always_ff @(posedge clk) begin
    if (rst) begin
      integ_r  <= 16'sd0;
      i_term_r <= 17'sd0;
    end else if (err_vld) begin
      integ_r  <= integ_nxt_s;
      i_term_r <= 17'(integ_sh_s);
    end
  end

  assign i_term_s = i_term_r;
`else
  assign i_term_s = 17'sd0;
`endif

  // Stage-2 mix: scale the correction, then apply it differentially.
  always_comb begin
    sum_s    = 17'(p_term_s) + 17'(d_term_s) + i_term_s;
    shr_s    = sum_s >>> 2;
    pid_w_s  = sat_signed(32'(shr_s), SPD_MIN, SPD_MAX);
    pid_s    = pid_w_s[11:0];
    fw_s     = $signed({3'b000, frwrd_p_r});
    lsum_s   = fw_s + 14'(pid_s);
    rsum_s   = fw_s - 14'(pid_s);
    lft_w_s  = sat_signed(32'(lsum_s), SPD_MIN, SPD_MAX);
    rght_w_s = sat_signed(32'(rsum_s), SPD_MIN, SPD_MAX);
    lft_s    = lft_w_s[11:0];
    rght_s   = rght_w_s[11:0];
  end

  // Output registers hold between samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_spd  <= 12'sd0;
      rght_spd <= 12'sd0;
      out_vld  <= 1'b0;
    end else begin
      out_vld <= vld_p_r;
      if (vld_p_r) begin
        lft_spd  <= zero_p_r ? 12'sd0 : lft_s;
        rght_spd <= zero_p_r ? 12'sd0 : rght_s;
      end
    end
  end

endmodule

// File: tb/tb_spd_ctrl.sv
// Scoreboard bench for spd_ctrl: ramp, steering, saturation, reset and streaming samples.
module tb_spd_ctrl;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               moving = 1'b0;
  logic [10:0]        frwrd_tgt = 11'd0;
  logic signed [11:0] err = 12'sd0;
  logic               err_vld = 1'b0;
  logic signed [11:0] lft_spd, rght_spd;
  logic               out_vld, at_spd;

  typedef struct {int l; int r;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int m_state, m_frwrd, m_prev;

  always #5 clk = ~clk;

  spd_ctrl dut (
    .clk(clk), .rst(rst), .moving(moving), .frwrd_tgt(frwrd_tgt),
    .err(err), .err_vld(err_vld), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .out_vld(out_vld), .at_spd(at_spd)
  );

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference: states 0=IDLE 1=RAMP 2=CRUISE 3=RAMP_DN, gains 3/5, step 16.
  task automatic model_step(input int e, input bit mv, input int tgt, output int l, output int r);
    int es, dif, pid, f, ns;
    f = m_frwrd;
    if (m_state == 0 && !(mv && tgt != 0)) begin
      f = 0; ns = 0;
    end else if (!mv) begin
      f = (f > 32) ? f - 32 : 0;
      ns = (f == 0) ? 0 : 3;
    end else begin
      if (f < tgt) f = (tgt - f > 16) ? f + 16 : tgt;
      else f = (f - tgt > 16) ? f - 16 : tgt;
      ns = (f != tgt) ? 1 : ((tgt == 0) ? 0 : 2);
    end
    es  = clamp(e, -512, 511);
    dif = clamp(es - m_prev, -128, 127);
    pid = clamp((es * 3 + dif * 5) >>> 2, -2048, 2047);
    m_prev = (ns == 0) ? 0 : es;
    m_state = ns;
    m_frwrd = f;
    l = (ns == 0) ? 0 : clamp(f + pid, -2048, 2047);
    r = (ns == 0) ? 0 : clamp(f - pid, -2048, 2047);
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b1; err_vld = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    sb.delete();
    m_state = 0; m_frwrd = 0; m_prev = 0;
  endtask

  // One isolated sample: checks latency, both speeds and at_spd.
  task automatic do_sample(input int e, input int exp_l, input int exp_r, input bit exp_at, input string nm);
    exp_t x;
    x.l = exp_l; x.r = exp_r;
    sb.push_back(x);
    @(negedge clk); err = 12'(e); err_vld = 1'b1;
    @(negedge clk); err_vld = 1'b0;
    checks++;
    if (out_vld !== 1'b0) begin failures++; $display("FAIL %s early_vld: got %b want 0", nm, out_vld); end
    @(negedge clk);
    checks++;
    if (out_vld !== 1'b1) begin failures++; $display("FAIL %s out_vld: got %b want 1", nm, out_vld); end
    x = sb.pop_front();
    checks++;
    if (lft_spd !== 12'(x.l)) begin failures++; $display("FAIL %s lft: got %0d want %0d", nm, lft_spd, x.l); end
    checks++;
    if (rght_spd !== 12'(x.r)) begin failures++; $display("FAIL %s rght: got %0d want %0d", nm, rght_spd, x.r); end
    checks++;
    if (at_spd !== exp_at) begin failures++; $display("FAIL %s at_spd: got %b want %b", nm, at_spd, exp_at); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (lft_spd !== 12'sd0 || rght_spd !== 12'sd0) begin
      failures++; $display("FAIL reset_spd: got %0d/%0d want 0/0", lft_spd, rght_spd);
    end
    checks++;
    if (out_vld !== 1'b0 || at_spd !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got vld=%b at=%b want 0/0", out_vld, at_spd);
    end
  endtask

  task automatic test_ramp_up();
    moving = 1'b1; frwrd_tgt = 11'd64;
    do_sample(0, 16, 16, 1'b0, "ramp1");
    do_sample(0, 32, 32, 1'b0, "ramp2");
    do_sample(0, 48, 48, 1'b0, "ramp3");
    do_sample(0, 64, 64, 1'b1, "ramp4");
  endtask

  task automatic test_err_step();
    do_sample(100, 264, -136, 1'b1, "step1");
    do_sample(100, 139, -11, 1'b1, "step2");
    do_sample(0, -61, 189, 1'b1, "step3");
    do_sample(0, 64, 64, 1'b1, "step4");
  endtask

  task automatic test_ramp_down();
    moving = 1'b0;
    do_sample(0, 32, 32, 1'b0, "down1");
    do_sample(0, 0, 0, 1'b0, "down2");
    do_sample(50, 0, 0, 1'b0, "down_idle");
  endtask

  task automatic test_retarget();
    moving = 1'b1; frwrd_tgt = 11'd64;
    for (int k = 1; k <= 4; k++) do_sample(0, 16 * k, 16 * k, k == 4, "reramp");
    frwrd_tgt = 11'd40;
    do_sample(0, 48, 48, 1'b0, "retgt1");
    do_sample(0, 40, 40, 1'b1, "retgt2");
  endtask

  task automatic test_saturation();
    int f;
    frwrd_tgt = 11'd2000;
    for (int k = 1; k <= 123; k++) begin
      f = (40 + 16 * k > 2000) ? 2000 : 40 + 16 * k;
      do_sample(0, f, f, f == 2000, "sat_ramp");
    end
    do_sample(2047, 2047, 1458, 1'b1, "sat_pos");
    do_sample(-2048, 1456, 2047, 1'b1, "sat_neg");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    moving = 1'b1; frwrd_tgt = 11'd64;
    do_sample(0, 16, 16, 1'b0, "mid1");
    @(negedge clk); err = 12'sd0; err_vld = 1'b1; rst = 1'b1;
    @(negedge clk); err_vld = 1'b0; rst = 1'b0;
    checks++;
    if (out_vld !== 1'b0) begin failures++; $display("FAIL mid_vld1: got %b want 0", out_vld); end
    @(negedge clk);
    checks++;
    if (out_vld !== 1'b0) begin failures++; $display("FAIL mid_vld2: got %b want 0", out_vld); end
    checks++;
    if (lft_spd !== 12'sd0 || rght_spd !== 12'sd0 || at_spd !== 1'b0) begin
      failures++; $display("FAIL mid_outs: got %0d/%0d at=%b want 0/0/0", lft_spd, rght_spd, at_spd);
    end
    do_sample(0, 16, 16, 1'b0, "mid_restart");
  endtask

  task automatic test_back_to_back();
    int errs[8] = '{0, 50, -30, 300, -600, 700, 5, 0};
    int l, r, seen;
    exp_t x;
    apply_reset();
    moving = 1'b1; frwrd_tgt = 11'd40;
    seen = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (out_vld === 1'b1) begin
        seen++;
        if (sb.size() == 0) begin
          checks++; failures++; $display("FAIL b2b_extra: got out_vld with empty queue want none");
        end else begin
          x = sb.pop_front();
          checks++;
          if (lft_spd !== 12'(x.l) || rght_spd !== 12'(x.r)) begin
            failures++;
            $display("FAIL b2b_data: got %0d/%0d want %0d/%0d", lft_spd, rght_spd, x.l, x.r);
          end
        end
      end
      if (cyc < 8) begin
        model_step(errs[cyc], 1'b1, 40, l, r);
        x.l = l; x.r = r;
        sb.push_back(x);
        err = 12'(errs[cyc]); err_vld = 1'b1;
      end else begin
        err_vld = 1'b0;
      end
    end
    checks++;
    if (seen != 8) begin failures++; $display("FAIL b2b_count: got %0d want 8", seen); end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_err_step();
    test_ramp_down();
    test_retarget();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spd_ctrl.md
Name: spd_ctrl

Overview:
- Heading/speed controller directly upstream of the motor drive stage; generates the signed lft_spd/rght_spd words that the motor driver scales by battery level and converts to PWM.
- Ramps forward speed toward a commanded target and adds a pipelined PD steering correction computed from a signed heading error sample stream.
- Output range is the full 12-bit signed range [-2048, 2047] with saturation.

Parameters:
- P_COEF, 3, signed 4-bit proportional gain.
- D_COEF, 5, signed 4-bit derivative gain.
- RAMP_INC, 16, forward-speed step per error sample (unsigned, 1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- moving  in  1  drive enable; low requests ramp-down to stop
- frwrd_tgt  in  11  unsigned target forward speed, 0..2047
- err  in  12  signed heading error
- err_vld  in  1  one-cycle strobe: err valid; also the ramp/sample tick
- lft_spd  out  12  signed left speed command
- rght_spd  out  12  signed right speed command
- out_vld  out  1  one-cycle strobe: new lft_spd/rght_spd
- at_spd  out  1  high while state is CRUISE

Behaviour:
- One clock; reset is synchronous and active-high. On rst: lft_spd=0, rght_spd=0, out_vld=0, at_spd=0, frwrd=0, prev_err=0, state=IDLE.
- All state updates (ramp, prev_err, FSM) occur only on cycles with err_vld=1; outputs hold between samples.
- Latency: err_vld in cycle N -> stage-1 register (P, D terms) in N+1 -> lft_spd/rght_spd registered with out_vld=1 in N+2. err_vld back-to-back every cycle is legal.
- Arithmetic per sample:
  - err_sat = err saturated to 10-bit signed [-512, 511].
  - P = err_sat * P_COEF (14 bits).
  - diff = err_sat - prev_err, saturated to 8-bit signed [-128, 127].
  - D = diff * D_COEF.
  - prev_err <= err_sat.
  - pid = (P + D) >>> 2 (arithmetic), saturated to 12-bit signed.
  - lft_spd = sat12(frwrd + pid); rght_spd = sat12(frwrd - pid). Sums are computed in 14-bit signed before saturation.
- FSM (evaluated on err_vld):
  - IDLE: frwrd=0; outputs forced 0 (out_vld still pulses); prev_err cleared. moving=1 and frwrd_tgt!=0 -> RAMP.
  - RAMP: frwrd steps toward frwrd_tgt by RAMP_INC in either direction, clipped to exactly frwrd_tgt (no overshoot). frwrd==frwrd_tgt after the step -> CRUISE. moving=0 -> RAMP_DN.
  - CRUISE: frwrd==frwrd_tgt. Target change -> RAMP. moving=0 -> RAMP_DN.
  - RAMP_DN: frwrd -= 2*RAMP_INC, clipped at 0; steering correction stays active. Reaching 0 -> IDLE (outputs 0 from that sample). moving=1 -> RAMP.
  - moving=1 with frwrd_tgt=0 stays in IDLE.
- Simultaneous rst and err_vld: rst wins; the in-flight pipeline sample is discarded and out_vld is not asserted.

Optional Feature:
- SPD_CTRL_INTEG_EN defined: a 16-bit signed saturating accumulator integ += err_sat, updated on err_vld only in CRUISE. It is cleared on rst, in IDLE, and on any transition out of CRUISE. I = integ >>> 6 is added into the P+D sum before the >>>2.
- Not defined: no accumulator, I term is 0, and latency is unchanged.

Decomposition:
- Package spd_ctrl_pkg holds:
  - state enum {IDLE, RAMP, CRUISE, RAMP_DN};
  - constants SPD_MAX=2047, SPD_MIN=-2048, ERR_MAX=511, ERR_MIN=-512, DIFF_MAX=127, DIFF_MIN=-128;
  - a generic signed saturate function.
- One sub-module, pd_term: stage-1 registers for err_sat, prev_err, P and D. The top holds the FSM, ramp and stage-2 mixing/saturation.

Test Plan:
- Ramp up: rst; moving=1, frwrd_tgt=64, err=0, err_vld every 4 cycles -> lft/rght = 16, 32, 48, 64; at_spd=1 from the 4th sample; each out_vld exactly 2 cycles after err_vld.
- Error step: in CRUISE at 64, err=100 -> lft=264, rght=-136. Repeat err=100 -> lft=139, rght=-11.
- Saturation: CRUISE at 2000, prev_err=0, err=2047 -> err_sat=511, pid=542, lft=2047 (clipped), rght=1458. Then err=-2048 -> diff clipped to -128.
- Ramp-down: at 64 in CRUISE, err=0, moving=0 -> outputs 32, then 0; state returns to IDLE; at_spd=0.
- Reset mid-operation: rst asserted coincident with the 2nd err_vld of a ramp -> no out_vld for that sample; next cycle all outputs 0, state IDLE. A following sample with moving=1 restarts at 16.
- Retarget: in CRUISE at 64, frwrd_tgt=40 -> lft=rght=48, then 40, then at_spd=1.
